// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and default width.
package shift_add_multiplier_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } mul_state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder used by the multiplier accumulate step: sum = a + b + cin.
module shift_add_multiplier_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier: sign-magnitude conversion, WIDTH accumulate
// iterations through one ripple adder, then sign fix-up of the 2*WIDTH-bit product.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d;
    logic             done_d;
    logic [PW-1:0]    product_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [PW-1:0]    raw_prod;

    // Partial product is the multiplicand gated by the current multiplier LSB
    assign add_b    = mplr_q[0] ? mcand_q : '0;
    assign raw_prod = {acc_q, mplr_q};

    shift_add_multiplier_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PREP;
            ST_PREP: state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy;
        done_d    = 1'b0;
        product_d = product;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    sgn_d  = is_signed;
                    neg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    busy_d = 1'b1;
                end
            end
            ST_PREP: begin
                // Magnitudes always fit unsigned, including the most-negative operand
                mcand_d = (sgn_q & a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
                mplr_d  = (sgn_q & b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
                acc_d   = '0;
                cnt_d   = '0;
            end
            ST_RUN: begin
                {acc_d, mplr_d} = {add_cout, add_sum, mplr_q[WIDTH-1:1]};
                cnt_d           = cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
                product_d = neg_q ? (~raw_prod + PW'(1)) : raw_prod;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            product <= product_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed vectors with hand-computed products.
module tb_shift_add_multiplier;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [PW-1:0] exp_q[$];
    logic          prev_done = 1'b0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse pops one expected product
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_width", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
        prev_done <= done;
    end

    // Issue one operation from IDLE and wait for its done pulse
    task automatic run_op(input logic sg, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [PW-1:0] exp, input bit chk_timing);
        int n;
        int busy_n;
        @(negedge clk);
        a = xa; b = xb; is_signed = sg; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_n = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        if (!done) check("timeout", 64'd1, 64'd0);
        if (chk_timing) begin
            check("latency", 64'(n - 1), 64'(W + 2));
            check("busy_cycles", 64'(busy_n), 64'(W + 2));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] held;
        int n;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",    64'(busy), 64'd0);
        check("reset_done",    64'(done), 64'd0);
        check("reset_product", product,   64'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd7,        32'd6,        64'd42,                 1'b1);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        run_op(1'b1, -32'sd3,      32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run_op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        run_op(1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000, 1'b0);
        run_op(1'b1, 32'h00000000, 32'hFFFFFFFF, 64'd0,                  1'b0);
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1,                  1'b0);
        run_op(1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000, 1'b0);
        run_op(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0);
        run_op(1'b1, 32'd12,       32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFAC, 1'b0);

        // Start held high while busy with changing operands; only the first op may run
        held = 64'hFFFFFFFF_FFFFFFAC;
        @(negedge clk);
        a = 32'd100; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'd300);
        n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            check("product_held", product, held);
            a = $urandom; b = $urandom; is_signed = 1'(n & 1);
            @(negedge clk);
            n++;
        end
        if (!done) check("timeout_hold", 64'd1, 64'd0);
        // Start in the done cycle is accepted
        a = 32'hFFFFFFFF; b = 32'd2; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'h00000001_FFFFFFFE);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done_start", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("timeout_back2back", 64'd1, 64'd0);

        // Reset in the middle of RUN discards the operation
        @(negedge clk);
        a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy",    64'(busy), 64'd0);
        check("midrst_done",    64'(done), 64'd0);
        check("midrst_product", product,   64'd0);
        rst = 1'b0;
        run_op(1'b1, 32'hFFFFFFFE, 32'd21, 64'hFFFFFFFF_FFFFFFD6, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
